// File: rtl/pim_pkg.sv
// Shared types and helpers for the multi-tile PIM convolution engine:
// FSM encoding, derived widths and the saturating ADC popcount.
package pim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Widest crossbar row the popcount helper handles; narrower rows are zero-extended.
    localparam int MAX_CROSS = 1024;

    function automatic int acc_width(input int adc_p, input int in_bits);
        return adc_p + in_bits + 1;
    endfunction

    function automatic int tile_sel_width(input int num_tiles);
        return (num_tiles > 1) ? $clog2(num_tiles) : 1;
    endfunction

    function automatic int sat_popcount(input logic [MAX_CROSS-1:0] v, input int adc_p);
        int cnt;
        int lim;
        cnt = 0;
        for (int i = 0; i < MAX_CROSS; i++) begin
            cnt = cnt + int'(v[i]);
        end
        lim = (1 << adc_p) - 1;
        return (cnt > lim) ? lim : cnt;
    endfunction

endpackage

// File: rtl/pim_crossbar_tile.sv
// One binary-weight crossbar tile: weight rows, write port, and a registered
// saturating popcount of (input plane AND selected row).
module pim_crossbar_tile
    import pim_pkg::*;
#(
    parameter int CROSS_SIZE = 64,
    parameter int DEPTH      = 6,
    parameter int ADC_P      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH-1:0]      wr_addr,
    input  logic [CROSS_SIZE-1:0] wr_data,
    input  logic                  issue,
    input  logic [DEPTH-1:0]      rd_addr,
    input  logic [CROSS_SIZE-1:0] in_plane,
    output logic [ADC_P-1:0]      adc
);

    logic [CROSS_SIZE-1:0] mem [2**DEPTH];
    logic [MAX_CROSS-1:0]  masked;
    int                    pc;

    // Weights are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign masked = MAX_CROSS'(in_plane & mem[rd_addr]);

    always_comb begin
        pc = sat_popcount(masked, ADC_P);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adc <= '0;
        end else if (issue) begin
            adc <= ADC_P'(pc);
        end
    end

endmodule

// File: rtl/pim_conv_engine.sv
// Multi-tile PIM convolution engine: streams input bit-planes LSB first into
// NUM_TILES crossbar tiles and shift-adds the ADC counts into per-tile dot products.
module pim_conv_engine
    import pim_pkg::*;
#(
    parameter int CROSS_SIZE = 64,
    parameter int DEPTH      = 6,
    parameter int ADC_P      = 8,
    parameter int IN_BITS    = 8,
    parameter int NUM_TILES  = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 en,
    input  logic                                                 signed_mode,
    input  logic [DEPTH-1:0]                                     address,
    input  logic [CROSS_SIZE-1:0]                                in_plane,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    output logic [NUM_TILES*acc_width(ADC_P, IN_BITS)-1:0]       out_data,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    input  logic                                                 wr_en,
    input  logic [tile_sel_width(NUM_TILES)-1:0]                 wr_tile,
    input  logic [DEPTH-1:0]                                     wr_addr,
    input  logic [CROSS_SIZE-1:0]                                wr_data,
    output logic                                                 wr_drop,
    output logic [1:0]                                           state_dbg
);

    localparam int ACC_W = acc_width(ADC_P, IN_BITS);
    localparam int CNT_W = $clog2(IN_BITS);

    // Handshakes: a plane transfers on a rising edge where in_valid & in_ready,
    // a result transfers where out_valid & out_ready; neither happens while en=0.
    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        p_k;
    logic                    p_valid;
    logic                    p_last;
    logic                    sgn_q;
    logic [DEPTH-1:0]        addr_q;
    logic [DEPTH-1:0]        rd_addr;
    logic                    hs;
    logic                    last_issue;
    logic                    wr_ok;
    logic [NUM_TILES*ADC_P-1:0] adc_bus;
    logic signed [ACC_W-1:0] acc      [NUM_TILES];
    logic signed [ACC_W-1:0] acc_next [NUM_TILES];
    logic [ACC_W-1:0]        term     [NUM_TILES];

    assign in_ready   = rst & en & ((state == IDLE) | (state == STREAM));
    assign hs         = in_valid & in_ready;
    assign last_issue = (state == STREAM) && (cnt == CNT_W'(IN_BITS - 1));
    assign rd_addr    = (state == IDLE) ? address : addr_q;
    assign wr_ok      = wr_en && (state == IDLE) && !hs && (int'(wr_tile) < NUM_TILES);
    assign state_dbg  = state;

    for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
        pim_crossbar_tile #(
            .CROSS_SIZE(CROSS_SIZE),
            .DEPTH     (DEPTH),
            .ADC_P     (ADC_P)
        ) u_tile (
            .clk     (clk),
            .rst     (rst),
            .we      (wr_ok && (int'(wr_tile) == t)),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .issue   (hs),
            .rd_addr (rd_addr),
            .in_plane(in_plane),
            .adc     (adc_bus[t*ADC_P +: ADC_P])
        );
    end

    // The MSB plane carries negative weight for two's-complement inputs.
    always_comb begin
        for (int t = 0; t < NUM_TILES; t++) begin
            term[t]     = ACC_W'(adc_bus[t*ADC_P +: ADC_P]) << p_k;
            acc_next[t] = (sgn_q && p_last) ? acc[t] - $signed(term[t])
                                            : acc[t] + $signed(term[t]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            p_valid   <= 1'b0;
            p_k       <= '0;
            p_last    <= 1'b0;
            sgn_q     <= 1'b0;
            addr_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int t = 0; t < NUM_TILES; t++) acc[t] <= '0;
        end else if (en) begin
            p_valid <= hs;
            if (hs) begin
                p_k    <= (state == IDLE) ? '0 : cnt;
                p_last <= last_issue;
            end
            if (p_valid) begin
                for (int t = 0; t < NUM_TILES; t++) acc[t] <= acc_next[t];
            end
            case (state)
                IDLE: begin
                    if (hs) begin
                        addr_q <= address;
                        sgn_q  <= signed_mode;
                        cnt    <= CNT_W'(1);
                        for (int t = 0; t < NUM_TILES; t++) acc[t] <= '0;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_issue) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end
                    end
                end
                // Wait until the final plane's add has landed in acc.
                DRAIN: begin
                    if (!p_valid) begin
                        for (int t = 0; t < NUM_TILES; t++) out_data[t*ACC_W +: ACC_W] <= acc[t];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Refusal pulse is independent of en, like the write port itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en & ~wr_ok;
        end
    end

endmodule

// File: tb/tb_pim_conv_engine.sv
// Directed bench for pim_conv_engine: main 4-plane/2-tile instance plus an
// ADC_P=5 instance sharing the same stimulus for the saturation case.
module tb_pim_conv_engine;
    import pim_pkg::*;

    localparam int CS  = 64;
    localparam int DP  = 6;
    localparam int IB  = 4;
    localparam int NT  = 2;
    localparam int AW  = 8 + IB + 1;
    localparam int AW5 = 5 + IB + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b1;
    logic          signed_mode = 1'b0;
    logic [DP-1:0] address = '0;
    logic [CS-1:0] in_plane = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_tile = 1'b0;
    logic [DP-1:0] wr_addr = '0;
    logic [CS-1:0] wr_data = '0;

    logic             in_ready, out_valid, wr_drop;
    logic [NT*AW-1:0] out_data;
    logic [1:0]       state_dbg;
    logic              in_ready5, out_valid5, wr_drop5;
    logic [NT*AW5-1:0] out_data5;
    logic [1:0]        state_dbg5;

    logic [CS-1:0] ones = '1;
    logic [CS-1:0] zero = '0;

    int n_cmp = 0;
    int n_err = 0;
    logic signed [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    pim_conv_engine #(.CROSS_SIZE(CS), .DEPTH(DP), .ADC_P(8), .IN_BITS(IB), .NUM_TILES(NT)) dut (
        .clk(clk), .rst(rst), .en(en), .signed_mode(signed_mode), .address(address),
        .in_plane(in_plane), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .wr_en(wr_en), .wr_tile(wr_tile), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_drop(wr_drop), .state_dbg(state_dbg)
    );

    pim_conv_engine #(.CROSS_SIZE(CS), .DEPTH(DP), .ADC_P(5), .IN_BITS(IB), .NUM_TILES(NT)) dut5 (
        .clk(clk), .rst(rst), .en(en), .signed_mode(signed_mode), .address(address),
        .in_plane(in_plane), .in_valid(in_valid), .in_ready(in_ready5),
        .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready),
        .wr_en(wr_en), .wr_tile(wr_tile), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_drop(wr_drop5), .state_dbg(state_dbg5)
    );

    // ---------------- helpers / drivers ----------------
    function automatic longint tile_val(input int t);
        return longint'($signed(out_data[t*AW +: AW]));
    endfunction

    function automatic longint tile5_val(input int t);
        return longint'($signed(out_data5[t*AW5 +: AW5]));
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic t, input logic [DP-1:0] a, input logic [CS-1:0] d,
                            input logic exp_drop);
        wr_en = 1'b1; wr_tile = t; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        check("wr_drop", wr_drop, exp_drop);
    endtask

    task automatic send_plane(input logic [CS-1:0] p);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_plane = p;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check("plane_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_plane = '0;
    endtask

    task automatic send_job(input logic sgn, input logic [DP-1:0] a, input logic [CS-1:0] p0,
                            input logic [CS-1:0] p1, input logic [CS-1:0] p2, input logic [CS-1:0] p3);
        signed_mode = sgn;
        address = a;
        send_plane(p0);
        send_plane(p1);
        send_plane(p2);
        send_plane(p3);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check("out_valid_wait", out_valid, 1);
    endtask

    // Scoreboard: pops one expected value per tile and compares.
    task automatic check_result(input string tag);
        for (int t = 0; t < NT; t++) begin
            check(tag, tile_val(t), longint'(exp_q.pop_front()));
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_consume_valid", out_valid, 0);
        check("post_consume_state", state_dbg, 2'(IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_wr_drop", wr_drop, 0);
        check("rst_state", state_dbg, 2'(IDLE));
        rst = 1'b1;
        step();
        check("idle_in_ready", in_ready, 1);

        do_write(1'b0, 6'd3, ones, 1'b0);
        do_write(1'b1, 6'd3, 64'h0000_0000_0000_000F, 1'b0);
        do_write(1'b0, 6'd0, ones, 1'b0);

        // Unsigned: every input = 5 -> 320 / 20, valid exactly two edges after last plane
        send_job(1'b0, 6'd3, ones, zero, ones, zero);
        check("lat_e0", out_valid, 0);
        step();
        check("lat_e1", out_valid, 0);
        step();
        check("lat_e2", out_valid, 1);
        check("lat_state", state_dbg, 2'(DONE));
        exp_q.push_back(320); exp_q.push_back(20);
        check_result("unsigned");
        consume();

        // Signed: every input = -1 -> -64 / -4
        send_job(1'b1, 6'd3, ones, ones, ones, ones);
        wait_result();
        exp_q.push_back(-64); exp_q.push_back(-4);
        check_result("signed");
        consume();

        // Saturation: 64 matches clip to 31 in the ADC_P=5 instance
        send_job(1'b0, 6'd0, ones, zero, zero, zero);
        wait_result();
        check("sat_adc5_valid", out_valid5, 1);
        check("sat_adc5_tile0", tile5_val(0), 31);
        check("sat_adc8_tile0", tile_val(0), 64);
        consume();

        // Backpressure: result held for 5 cycles, next job's plane waits
        send_job(1'b0, 6'd3, ones, zero, ones, zero);
        wait_result();
        signed_mode = 1'b1;
        address = 6'd3;
        in_valid = 1'b1;
        in_plane = ones;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_tile0", tile_val(0), 320);
            check("bp_tile1", tile_val(1), 20);
        end
        out_ready = 1'b1;
        check("bp_hs_in_ready", in_ready, 0);
        step();
        out_ready = 1'b0;
        check("bp_after_valid", out_valid, 0);
        check("bp_after_state", state_dbg, 2'(IDLE));
        check("bp_after_in_ready", in_ready, 1);
        step();
        check("bp_next_job_started", state_dbg, 2'(STREAM));
        in_valid = 1'b0;
        send_plane(ones);
        send_plane(ones);
        send_plane(ones);
        wait_result();
        exp_q.push_back(-64); exp_q.push_back(-4);
        check_result("bp_next_job");
        consume();

        // en and in_valid gaps mid-stream
        signed_mode = 1'b0;
        address = 6'd3;
        send_plane(ones);
        send_plane(zero);
        en = 1'b0;
        in_valid = 1'b1;
        in_plane = ones;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en_gap_in_ready", in_ready, 0);
            check("en_gap_state", state_dbg, 2'(STREAM));
        end
        en = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        check("valid_gap_state", state_dbg, 2'(STREAM));
        send_plane(ones);
        send_plane(zero);
        wait_result();
        exp_q.push_back(320); exp_q.push_back(20);
        check_result("gaps");
        consume();

        // Write during STREAM is refused and leaves weights intact
        send_plane(ones);
        send_plane(zero);
        do_write(1'b0, 6'd3, zero, 1'b1);
        step();
        check("wr_drop_pulse_end", wr_drop, 0);
        send_plane(ones);
        send_plane(zero);
        wait_result();
        exp_q.push_back(320); exp_q.push_back(20);
        check_result("stream_write_refused");
        consume();

        // Write colliding with an IDLE plane handshake is refused; then reset mid-job
        signed_mode = 1'b1;
        address = 6'd3;
        in_valid = 1'b1;
        in_plane = ones;
        wr_en = 1'b1; wr_tile = 1'b1; wr_addr = 6'd3; wr_data = zero;
        step();
        wr_en = 1'b0;
        in_valid = 1'b0;
        check("idle_hs_wr_drop", wr_drop, 1);
        send_plane(ones);
        rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_state", state_dbg, 2'(IDLE));
        check("abort_in_ready", in_ready, 0);
        step();
        rst = 1'b1;
        step();
        check("abort_idle_again", out_valid, 0);
        send_job(1'b1, 6'd3, ones, ones, ones, ones);
        wait_result();
        exp_q.push_back(-64); exp_q.push_back(-4);
        check_result("after_reset");
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
